fifo_sync_param: RTL and testbench

- Parametrised synchronous single-clock FIFO. Successor to the current 8-bit FIFO that the UVM fifo agent drives.
- Generalised in data width and depth.
- Adds almost-full/almost-empty thresholds, occupancy count, overflow/underflow pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Keeps the existing signal set, so the fifo_if-based agent binds with only extra monitor inputs.

---
 rtl/fifo_sync_param_pkg.sv | 27 ++
 rtl/fifo_sync_param_if.sv | 31 +++
 rtl/fifo_sync_param_mem.sv | 23 ++
 rtl/fifo_sync_param.sv | 129 ++++++++++++
 tb/tb_fifo_sync_param.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_sync_param_pkg.sv
// Shared widths, parameter legality and read-mode encoding for the parametrised sync FIFO.
package fifo_pkg;

    typedef enum logic [0:0] {
        STD  = 1'b0,
        FWFT = 1'b1
    } read_mode_e;

    localparam int MIN_DEPTH  = 2;
    localparam int MIN_AF_THR = 1;

    function automatic int calc_ptr_w(input int d);
        return $clog2(d) + 1;
    endfunction

    function automatic int calc_cnt_w(input int d);
        return $clog2(d) + 1;
    endfunction

    // Power-of-two depth keeps the wrap bit trick valid for full/empty and count.
    function automatic bit params_legal(input int d, input int af_thr, input int ae_thr);
        return (d >= MIN_DEPTH) && ((d & (d - 1)) == 0) &&
               (af_thr >= MIN_AF_THR) && (af_thr <= d) &&
               (ae_thr >= 0) && (ae_thr <= d - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Handshake/data bundle between a FIFO user (master) and the FIFO itself (slave).
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int data_size = 8,
    parameter int depth     = 16
);
    logic [data_size-1:0]          data_in;
    logic                          write_en;
    logic                          read_en;
    logic [data_size-1:0]          data_out;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          almost_full;
    logic                          almost_empty;
    logic [calc_cnt_w(depth)-1:0]  count;
    logic                          overflow;
    logic                          underflow;

    modport master (
        output data_in, write_en, read_en,
        input  data_out, fifo_full, fifo_empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  data_in, write_en, read_en,
        output data_out, fifo_full, fifo_empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, contents never reset.
module fifo_mem #(
    parameter int data_size = 8,
    parameter int depth     = 16
) (
    input  logic                         clock,
    input  logic                         we_i,
    input  logic [$clog2(depth)-1:0]     waddr_i,
    input  logic [data_size-1:0]         wdata_i,
    input  logic [$clog2(depth)-1:0]     raddr_i,
    output logic [data_size-1:0]         rdata_o
);
    logic [data_size-1:0] mem_q [depth];

    // Storage write port.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy, overflow/underflow pulses
// and selectable standard or first-word-fall-through read.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int data_size        = 8,
    parameter int depth            = 16,
    parameter int almost_full_thr  = depth - 2,
    parameter int almost_empty_thr = 2,
    parameter int fwft             = 0
) (
    input  logic   clock,
    input  logic   reset,
    fifo_if.slave  bus
);
    localparam int ptr_w = calc_ptr_w(depth);
    localparam int aw    = ptr_w - 1;
    localparam int cnt_w = calc_cnt_w(depth);

    if (!params_legal(depth, almost_full_thr, almost_empty_thr)) begin : g_bad_params
        $error("fifo_sync_param: illegal depth or threshold parameters");
    end

    logic [ptr_w-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0]     count_s;
    logic                 fifo_empty_s, fifo_full_s;
    logic                 rd_ok_s, wr_ok_s;
    logic                 overflow_q, overflow_d, underflow_q, underflow_d;
    logic [data_size-1:0] mem_rdata_s;

    // Occupancy is the wrap-aware pointer distance; all flags decode from it.
    always_comb begin
        count_s      = cnt_w'(wr_ptr_q - rd_ptr_q);
        fifo_empty_s = (count_s == cnt_w'(0));
        fifo_full_s  = (count_s == cnt_w'(depth));
        rd_ok_s      = bus.read_en & ~fifo_empty_s;
        wr_ok_s      = bus.write_en & (~fifo_full_s | rd_ok_s);
    end

    // Next-state for pointers and the event pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + ptr_w'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + ptr_w'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        overflow_d  = bus.write_en & ~wr_ok_s;
        underflow_d = bus.read_en & fifo_empty_s;
    end

    // Pointer and pulse registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .data_size (data_size),
        .depth     (depth)
    ) u_mem (
        .clock   (clock),
        .we_i    (wr_ok_s),
        .waddr_i (wr_ptr_q[aw-1:0]),
        .wdata_i (bus.data_in),
        .raddr_i (rd_ptr_q[aw-1:0]),
        .rdata_o (mem_rdata_s)
    );

    if (fwft == int'(FWFT)) begin : g_fwft
        logic [data_size-1:0] data_out_s;

        // Head word is presented directly; zero while empty.
        always_comb begin
            if (fifo_empty_s) begin
                data_out_s = '0;
            end else begin
                data_out_s = mem_rdata_s;
            end
        end

        assign bus.data_out = data_out_s;
    end else begin : g_std
        logic [data_size-1:0] dout_q, dout_d;

        // Head is captured only on an accepted pop; at full with a write the old head is read.
        always_comb begin
            if (rd_ok_s) begin
                dout_d = mem_rdata_s;
            end else begin
                dout_d = dout_q;
            end
        end

        // Standard-mode output register.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign bus.data_out = dout_q;
    end

    assign bus.count        = count_s;
    assign bus.fifo_empty   = fifo_empty_s;
    assign bus.fifo_full    = fifo_full_s;
    assign bus.almost_full  = (count_s >= cnt_w'(almost_full_thr));
    assign bus.almost_empty = (count_s <= cnt_w'(almost_empty_thr));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench: one standard-mode and one FWFT-mode FIFO, depth 8, width 8, thresholds 6/2.
module tb_fifo_sync_param;
    import fifo_pkg::*;

    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    logic [7:0] exp_q [$];

    fifo_if #(.data_size(8), .depth(8)) bus_s ();
    fifo_if #(.data_size(8), .depth(8)) bus_f ();

    fifo_sync_param #(.data_size(8), .depth(8), .almost_full_thr(6), .almost_empty_thr(2),
                      .fwft(int'(STD))) u_std (.clock(clock), .reset(reset), .bus(bus_s));
    fifo_sync_param #(.data_size(8), .depth(8), .almost_full_thr(6), .almost_empty_thr(2),
                      .fwft(int'(FWFT))) u_fwft (.clock(clock), .reset(reset), .bus(bus_f));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        total_cnt++; if (bus_s.count !== 4'd0 || bus_s.fifo_empty !== 1'b1 || bus_s.almost_empty !== 1'b1)
            $display("FAIL reset_std_empty count=%0d empty=%b ae=%b exp 0/1/1", bus_s.count, bus_s.fifo_empty, bus_s.almost_empty); else pass_cnt++;
        total_cnt++; if (bus_s.fifo_full !== 1'b0 || bus_s.almost_full !== 1'b0 || bus_s.overflow !== 1'b0 || bus_s.underflow !== 1'b0)
            $display("FAIL reset_std_flags full=%b af=%b ovf=%b unf=%b exp 0000", bus_s.fifo_full, bus_s.almost_full, bus_s.overflow, bus_s.underflow); else pass_cnt++;
        total_cnt++; if (bus_s.data_out !== 8'h00 || bus_f.data_out !== 8'h00)
            $display("FAIL reset_data_out std=%h fwft=%h exp 00/00", bus_s.data_out, bus_f.data_out); else pass_cnt++;
        step();
        step();
        reset = 1'b1;
        step();
        total_cnt++; if (bus_s.count !== 4'd0 || bus_f.fifo_empty !== 1'b1)
            $display("FAIL reset_release count=%0d fwft_empty=%b exp 0/1", bus_s.count, bus_f.fifo_empty); else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            bus_s.write_en = 1'b1;
            bus_s.data_in  = 8'(i);
            step();
            total_cnt++; if (bus_s.count !== 4'(i) || bus_s.almost_full !== (i >= 6) || bus_s.fifo_full !== (i == 8)
                             || bus_s.almost_empty !== (i <= 2) || bus_s.fifo_empty !== 1'b0)
                $display("FAIL fill_%0d count=%0d af=%b full=%b ae=%b empty=%b", i, bus_s.count,
                         bus_s.almost_full, bus_s.fifo_full, bus_s.almost_empty, bus_s.fifo_empty); else pass_cnt++;
        end
        bus_s.write_en = 1'b0;
        total_cnt++; if (bus_s.data_out !== 8'h00)
            $display("FAIL fill_no_read_out got %h exp 00", bus_s.data_out); else pass_cnt++;
    endtask

    task automatic test_overflow();
        bus_s.write_en = 1'b1;
        bus_s.data_in  = 8'hAA;
        step();
        bus_s.write_en = 1'b0;
        total_cnt++; if (bus_s.overflow !== 1'b1 || bus_s.count !== 4'd8)
            $display("FAIL ovf_pulse ovf=%b count=%0d exp 1/8", bus_s.overflow, bus_s.count); else pass_cnt++;
        step();
        total_cnt++; if (bus_s.overflow !== 1'b0 || bus_s.count !== 4'd8)
            $display("FAIL ovf_clear ovf=%b count=%0d exp 0/8", bus_s.overflow, bus_s.count); else pass_cnt++;
        for (int i = 1; i <= 8; i++) begin
            bus_s.read_en = 1'b1;
            step();
            total_cnt++; if (bus_s.data_out !== 8'(i) || bus_s.count !== 4'(8 - i))
                $display("FAIL drain_%0d data=%h count=%0d exp %h/%0d", i, bus_s.data_out, bus_s.count, 8'(i), 8 - i); else pass_cnt++;
        end
        bus_s.read_en = 1'b0;
        total_cnt++; if (bus_s.fifo_empty !== 1'b1 || bus_s.underflow !== 1'b0)
            $display("FAIL drain_empty empty=%b unf=%b exp 1/0", bus_s.fifo_empty, bus_s.underflow); else pass_cnt++;
    endtask

    task automatic test_underflow();
        bus_s.read_en = 1'b1;
        step();
        bus_s.read_en = 1'b0;
        total_cnt++; if (bus_s.underflow !== 1'b1 || bus_s.data_out !== 8'h08 || bus_s.count !== 4'd0)
            $display("FAIL unf_pulse unf=%b data=%h count=%0d exp 1/08/0", bus_s.underflow, bus_s.data_out, bus_s.count); else pass_cnt++;
        step();
        total_cnt++; if (bus_s.underflow !== 1'b0)
            $display("FAIL unf_clear got %b exp 0", bus_s.underflow); else pass_cnt++;
    endtask

    task automatic test_rw_full();
        for (int i = 0; i < 8; i++) begin
            bus_s.write_en = 1'b1;
            bus_s.data_in  = 8'h11 + 8'(i);
            step();
        end
        bus_s.data_in = 8'h55;
        bus_s.read_en = 1'b1;
        step();
        bus_s.write_en = 1'b0;
        total_cnt++; if (bus_s.data_out !== 8'h11 || bus_s.count !== 4'd8 || bus_s.overflow !== 1'b0)
            $display("FAIL rw_full data=%h count=%0d ovf=%b exp 11/8/0", bus_s.data_out, bus_s.count, bus_s.overflow); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            step();
            total_cnt++; if (bus_s.data_out !== ((i == 7) ? 8'h55 : 8'h12 + 8'(i)))
                $display("FAIL rw_full_drain_%0d got %h", i, bus_s.data_out); else pass_cnt++;
        end
        bus_s.read_en = 1'b0;
    endtask

    task automatic test_rw_empty();
        bus_s.write_en = 1'b1;
        bus_s.read_en  = 1'b1;
        bus_s.data_in  = 8'h77;
        step();
        bus_s.write_en = 1'b0;
        total_cnt++; if (bus_s.count !== 4'd1 || bus_s.underflow !== 1'b1 || bus_s.data_out !== 8'h55)
            $display("FAIL rw_empty count=%0d unf=%b data=%h exp 1/1/55", bus_s.count, bus_s.underflow, bus_s.data_out); else pass_cnt++;
        step();
        bus_s.read_en = 1'b0;
        total_cnt++; if (bus_s.data_out !== 8'h77 || bus_s.count !== 4'd0 || bus_s.underflow !== 1'b0)
            $display("FAIL rw_empty_pop data=%h count=%0d unf=%b exp 77/0/0", bus_s.data_out, bus_s.count, bus_s.underflow); else pass_cnt++;
    endtask

    task automatic test_fwft();
        total_cnt++; if (bus_f.data_out !== 8'h00)
            $display("FAIL fwft_idle got %h exp 00", bus_f.data_out); else pass_cnt++;
        bus_f.write_en = 1'b1;
        bus_f.data_in  = 8'h3C;
        step();
        bus_f.write_en = 1'b0;
        total_cnt++; if (bus_f.data_out !== 8'h3C || bus_f.fifo_empty !== 1'b0)
            $display("FAIL fwft_show data=%h empty=%b exp 3c/0", bus_f.data_out, bus_f.fifo_empty); else pass_cnt++;
        step();
        total_cnt++; if (bus_f.data_out !== 8'h3C)
            $display("FAIL fwft_hold got %h exp 3c", bus_f.data_out); else pass_cnt++;
        bus_f.read_en = 1'b1;
        step();
        bus_f.read_en = 1'b0;
        total_cnt++; if (bus_f.data_out !== 8'h00 || bus_f.fifo_empty !== 1'b1)
            $display("FAIL fwft_pop data=%h empty=%b exp 00/1", bus_f.data_out, bus_f.fifo_empty); else pass_cnt++;
        bus_f.write_en = 1'b1;
        bus_f.data_in  = 8'hA1;
        step();
        bus_f.data_in  = 8'hA2;
        step();
        bus_f.write_en = 1'b0;
        total_cnt++; if (bus_f.data_out !== 8'hA1 || bus_f.count !== 4'd2)
            $display("FAIL fwft_head data=%h count=%0d exp a1/2", bus_f.data_out, bus_f.count); else pass_cnt++;
        bus_f.read_en = 1'b1;
        step();
        total_cnt++; if (bus_f.data_out !== 8'hA2 || bus_f.count !== 4'd1)
            $display("FAIL fwft_next data=%h count=%0d exp a2/1", bus_f.data_out, bus_f.count); else pass_cnt++;
        step();
        bus_f.read_en = 1'b0;
        total_cnt++; if (bus_f.data_out !== 8'h00 || bus_f.fifo_empty !== 1'b1)
            $display("FAIL fwft_drained data=%h empty=%b exp 00/1", bus_f.data_out, bus_f.fifo_empty); else pass_cnt++;
    endtask

    task automatic test_wrap_reset();
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            bus_s.write_en = 1'b1;
            bus_s.data_in  = 8'h31 + 8'(i);
            exp_q.push_back(bus_s.data_in);
            step();
        end
        bus_s.read_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus_s.data_in = 8'h40 + 8'(k);
            step();
            exp = exp_q.pop_front();
            exp_q.push_back(8'h40 + 8'(k));
            total_cnt++; if (bus_s.data_out !== exp || bus_s.count !== 4'd3)
                $display("FAIL wrap_%0d data=%h count=%0d exp %h/3", k, bus_s.data_out, bus_s.count, exp); else pass_cnt++;
        end
        bus_s.write_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp = exp_q.pop_front();
            total_cnt++; if (bus_s.data_out !== exp)
                $display("FAIL wrap_drain_%0d got %h exp %h", i, bus_s.data_out, exp); else pass_cnt++;
        end
        bus_s.read_en  = 1'b0;
        bus_s.write_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_s.data_in = 8'hC0 + 8'(i);
            step();
        end
        total_cnt++; if (bus_s.count !== 4'd5)
            $display("FAIL pre_reset_count got %0d exp 5", bus_s.count); else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++; if (bus_s.count !== 4'd0 || bus_s.fifo_empty !== 1'b1 || bus_s.almost_empty !== 1'b1
                         || bus_s.almost_full !== 1'b0 || bus_s.data_out !== 8'h00)
            $display("FAIL async_reset count=%0d empty=%b ae=%b af=%b data=%h exp 0/1/1/0/00", bus_s.count,
                     bus_s.fifo_empty, bus_s.almost_empty, bus_s.almost_full, bus_s.data_out); else pass_cnt++;
        step();
        reset = 1'b1;
        bus_s.data_in = 8'hE7;
        step();
        bus_s.write_en = 1'b0;
        total_cnt++; if (bus_s.count !== 4'd1)
            $display("FAIL post_reset_write count=%0d exp 1", bus_s.count); else pass_cnt++;
        bus_s.read_en = 1'b1;
        step();
        bus_s.read_en = 1'b0;
        total_cnt++; if (bus_s.data_out !== 8'hE7 || bus_s.fifo_empty !== 1'b1)
            $display("FAIL post_reset_read data=%h empty=%b exp e7/1", bus_s.data_out, bus_s.fifo_empty); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b0;
        bus_s.data_in = 8'h00; bus_s.write_en = 1'b0; bus_s.read_en = 1'b0;
        bus_f.data_in = 8'h00; bus_f.write_en = 1'b0; bus_f.read_en = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_rw_full();
        test_rw_empty();
        test_fwft();
        test_wrap_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
